ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter; the send direction of the PS/2 link whose receive side feeds the mouse bus.
- Sends one command byte (e.g. 0xF4 enable reporting, 0xFF reset) to the mouse over the shared ps2_clk/ps2_data lines.
- Runs in the pclk (40 MHz) domain.
- Drives the lines open-drain through output-enable signals. The top level builds the tristate: line = oe ? 0 : Z.

---
 rtl/ps2_host_tx.sv | 128 ++++++++++++
 tb/tb_ps2_host_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device sender: inhibit, request-to-send, 10 bits on device clock falls, ACK, release.
// Accept to clk_oe is one cycle; tx_ready only in IDLE, so a held request waits until the link is free.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 4000,
  parameter int REQ_CYCLES     = 40,
  parameter int TIMEOUT_CYCLES = 600000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout_err
);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, RELEASE} state_t;

  localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] REQ_LAST = 20'(REQ_CYCLES - 1);
  localparam logic [19:0] TO_LIMIT = 20'(TIMEOUT_CYCLES);

  state_t      state, state_nxt;
  logic [19:0] cnt;
  logic [3:0]  bit_idx;
  logic [9:0]  frame;
  logic        data_drive;
  logic        clk_meta, clk_sync, clk_prev;
  logic        data_meta, data_sync;
  logic        fe;
  logic        lines_high;
  logic        timed_out;

  assign fe         = clk_prev & ~clk_sync;
  assign lines_high = clk_sync & data_sync;

  // A successful release on the last allowed cycle still counts as done.
  always_comb begin
    timed_out = 1'b0;
    if ((state == SEND || state == ACK || state == RELEASE) && cnt == TO_LIMIT)
      timed_out = !(state == RELEASE && lines_high);
  end

  always_ff @(posedge pclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tx_valid) state_nxt = INHIBIT;
      INHIBIT: if (cnt == INH_LAST) state_nxt = REQ;
      REQ:     if (cnt == REQ_LAST) state_nxt = SEND;
      SEND: begin
        if (timed_out)                  state_nxt = IDLE;
        else if (fe && bit_idx == 4'd9) state_nxt = ACK;
      end
      ACK: begin
        if (timed_out) state_nxt = IDLE;
        else if (fe)   state_nxt = RELEASE;
      end
      RELEASE: if (lines_high || timed_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_ready    = (state == IDLE);
    busy        = (state != IDLE);
    ps2_clk_oe  = (state == INHIBIT) || (state == REQ);
    ps2_data_oe = (state == REQ) || (state == SEND && data_drive && !timed_out);
    done        = (state == RELEASE) && lines_high;
    timeout_err = timed_out;
  end

  // SEND and ACK share one timeout window, so the count runs on across that step.
  always_ff @(posedge pclk) begin
    if (rst) begin
      cnt        <= '0;
      bit_idx    <= '0;
      frame      <= '0;
      data_drive <= 1'b0;
      ack_ok     <= 1'b0;
      clk_meta   <= 1'b1;
      clk_sync   <= 1'b1;
      clk_prev   <= 1'b1;
      data_meta  <= 1'b1;
      data_sync  <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;

      if (state_nxt != state && !(state == SEND && state_nxt == ACK))
        cnt <= '0;
      else if (state != IDLE)
        cnt <= cnt + 20'd1;

      if (state == IDLE && tx_valid) begin
        frame  <= {1'b1, ~^tx_data, tx_data};
        ack_ok <= 1'b0;
      end

      if (state == REQ) begin
        data_drive <= 1'b1;
        bit_idx    <= '0;
      end

      if (state == SEND && fe && !timed_out) begin
        data_drive <= ~frame[bit_idx];
        bit_idx    <= bit_idx + 4'd1;
      end

      if (state == ACK && fe && !timed_out)
        ack_ok <= ~data_sync;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model, queue of expected completions checked by a monitor.
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int REQ = 4;
  localparam int TO  = 5000;

  logic       pclk     = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, timeout_err;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk  = 1'b1;
  logic       dev_data = 1'b1;
  logic [9:0] cap_frame = '0;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (REQ),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .ack_ok     (ack_ok),
    .timeout_err(timeout_err)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;

  typedef struct {
    string      name;
    bit         is_timeout;
    bit         ack;
    logic [9:0] frame;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Line timing observed per transfer.
  int   hs_cyc = 0, clk_rise_cyc = 0, send_cyc = 0;
  int   hs_lag = -1, data_lag = -1, clk_len = -1;
  logic prev_clk_oe = 1'b0, prev_data_oe = 1'b0;

  always @(negedge pclk) begin
    if (tx_valid === 1'b1 && tx_ready === 1'b1) hs_cyc = cyc;
    if (ps2_clk_oe === 1'b1 && prev_clk_oe !== 1'b1) begin
      clk_rise_cyc = cyc;
      hs_lag       = cyc - hs_cyc;
      data_lag     = -1;
    end
    if (ps2_data_oe === 1'b1 && prev_data_oe !== 1'b1 && ps2_clk_oe === 1'b1)
      data_lag = cyc - clk_rise_cyc;
    if (ps2_clk_oe === 1'b0 && prev_clk_oe === 1'b1) begin
      clk_len  = cyc - clk_rise_cyc;
      send_cyc = cyc;
    end
    prev_clk_oe  = ps2_clk_oe;
    prev_data_oe = ps2_data_oe;
  end

  initial begin : completion_monitor
    exp_t e;
    forever begin
      @(negedge pclk);
      if (done === 1'b1 || timeout_err === 1'b1) begin
        pulse_cnt++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual done=%0b timeout_err=%0b required=none", done, timeout_err);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_timeout_err"}, 32'(timeout_err), 32'(e.is_timeout));
          chk({e.name, "_done"}, 32'(done), 32'(!e.is_timeout));
          if (!e.is_timeout) begin
            chk({e.name, "_ack_ok"}, 32'(ack_ok), 32'(e.ack));
            chk({e.name, "_frame"}, 32'(cap_frame), 32'(e.frame));
            chk({e.name, "_clk_oe_len"}, 32'(clk_len), 32'(INH + REQ));
            chk({e.name, "_data_oe_lag"}, 32'(data_lag), 32'(INH));
            chk({e.name, "_accept_to_clk_oe"}, 32'(hs_lag), 32'd1);
          end else begin
            chk({e.name, "_lag_from_send"}, 32'(cyc - send_cyc), 32'(TO));
            chk({e.name, "_oe_at_pulse"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
          end
          @(negedge pclk);
          chk({e.name, "_ready_after"}, 32'(tx_ready), 32'd1);
          chk({e.name, "_oe_after"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
          chk({e.name, "_pulse_width"}, 32'({done, timeout_err}), 32'd0);
        end
      end
    end
  end

  // Device: waits for request-to-send, then clocks n_fe falls at a 50-cycle period.
  task automatic device(input int n_fe, input bit ack);
    int w;
    w = 0;
    cap_frame = '0;
    do begin
      @(negedge pclk);
      w++;
    end while (!(busy === 1'b1 && ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && w < 2000);
    chk("dev_request_seen", 32'(w < 2000), 32'd1);
    if (w >= 2000) return;
    for (int i = 0; i < n_fe && i < 10; i++) begin
      repeat (25) @(posedge pclk);
      #1 dev_clk = 1'b0;
      repeat (25) @(posedge pclk);
      #1 dev_clk = 1'b1;
      cap_frame[i] = ps2_data_in;
    end
    if (n_fe >= 11) begin
      repeat (20) @(posedge pclk);
      #1 if (ack) dev_data = 1'b0;
      repeat (5) @(posedge pclk);
      #1 dev_clk = 1'b0;
      repeat (25) @(posedge pclk);
      #1 dev_clk = 1'b1;
      dev_data = 1'b1;
    end
  endtask

  task automatic issue(input logic [7:0] d);
    @(posedge pclk);
    #1 tx_data = d;
    tx_valid = 1'b1;
    @(posedge pclk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_pulse(input string name);
    int w;
    w = 0;
    do begin
      @(negedge pclk);
      w++;
    end while (!(done === 1'b1 || timeout_err === 1'b1) && w < 20000);
    chk({name, "_pulse_seen"}, 32'(w < 20000), 32'd1);
  endtask

  task automatic run(input string name, input logic [7:0] d, input logic [9:0] f,
                     input int n_fe, input bit ack);
    sb.push_back('{name: name, is_timeout: 1'b0, ack: ack, frame: f});
    issue(d);
    device(n_fe, ack);
    wait_pulse(name);
    repeat (10) @(negedge pclk);
  endtask

  initial begin : stimulus
    int pc;
    rst = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ack_ok", 32'(ack_ok), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    @(posedge pclk);
    #1 rst = 1'b0;
    repeat (5) @(posedge pclk);

    // Frames are {stop, parity, data}: F4 has five ones (parity 0), FF/00 even (parity 1).
    run("f4_ack",   8'hF4, 10'h2F4, 11, 1'b1);
    run("ff_ack",   8'hFF, 10'h3FF, 11, 1'b1);
    run("00_ack",   8'h00, 10'h300, 11, 1'b1);
    run("f4_noack", 8'hF4, 10'h2F4, 11, 1'b0);

    sb.push_back('{name: "stall", is_timeout: 1'b1, ack: 1'b0, frame: 10'h000});
    issue(8'hF4);
    device(5, 1'b1);
    wait_pulse("stall");
    repeat (10) @(negedge pclk);
    run("f4_after_stall", 8'hF4, 10'h2F4, 11, 1'b1);

    pc = pulse_cnt;
    issue(8'hF4);
    device(3, 1'b1);
    @(posedge pclk);
    #1 rst = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    chk("midrst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
    chk("midrst_pulses", 32'({done, timeout_err}), 32'd0);
    @(posedge pclk);
    #1 rst = 1'b0;
    repeat (200) @(negedge pclk);
    chk("midrst_no_pulse_after", 32'(pulse_cnt - pc), 32'd0);

    // 0xAA stays offered for the whole 0xF4 transfer; AA: four ones, parity 1.
    sb.push_back('{name: "hold_f4", is_timeout: 1'b0, ack: 1'b1, frame: 10'h2F4});
    sb.push_back('{name: "hold_aa", is_timeout: 1'b0, ack: 1'b1, frame: 10'h3AA});
    @(posedge pclk);
    #1 tx_data = 8'hF4;
    tx_valid = 1'b1;
    @(posedge pclk);
    #1 tx_data = 8'hAA;
    device(11, 1'b1);
    wait_pulse("hold_f4");
    @(negedge pclk);
    chk("hold_aa_accept_after_done", 32'(tx_ready & tx_valid), 32'd1);
    @(posedge pclk);
    #1 tx_valid = 1'b0;
    device(11, 1'b1);
    wait_pulse("hold_aa");
    repeat (10) @(negedge pclk);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #(600000);
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
